// File: rtl/elevator_call_panel.sv
// elevator_call_panel: hall-call capture, request-line drive and door dwell timing
// for a four-floor elevator controller.
module elevator_call_panel #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_btn,
    input  logic [1:0] i_floor,
    output logic       o_ra,
    output logic       o_rb,
    output logic       o_rc,
    output logic       o_rd,
    output logic       o_door_open,
    output logic       o_busy,
    output logic [2:0] o_pending_cnt
);
    typedef enum logic [1:0] {IDLE, SERVE, DOOR} state_t;

    localparam logic [7:0] RELOAD = 8'(DWELL_CYCLES - 1);

    state_t     r_state, w_state_n;
    logic [3:0] r_btn_prev, r_pending, w_pending_n, w_press, w_floor_oh, w_df_oh;
    logic [3:0] r_req, w_req_n;
    logic [1:0] r_df, w_df_n;
    logic [7:0] r_cnt, w_cnt_n;
    logic [2:0] r_pcnt, w_pcnt_n;
    logic       r_door, r_busy;

    assign w_press    = i_btn & ~r_btn_prev;
    assign w_floor_oh = 4'b0001 << i_floor;
    assign w_df_oh    = 4'b0001 << r_df;

    always_comb begin
        w_state_n   = r_state;
        w_df_n      = r_df;
        w_cnt_n     = r_cnt;
        w_pending_n = r_pending | w_press;
        if (r_state == DOOR) begin
            // A press on the open floor only extends the dwell.
            w_pending_n = r_pending | (w_press & ~w_df_oh);
            if (w_press[r_df])
                w_cnt_n = RELOAD;
            else if (r_cnt != '0)
                w_cnt_n = r_cnt - 8'd1;
            else
                w_state_n = (w_pending_n != '0) ? SERVE : IDLE;
        end else if (w_pending_n[i_floor]) begin
            w_state_n   = DOOR;
            w_df_n      = i_floor;
            w_cnt_n     = RELOAD;
            w_pending_n = w_pending_n & ~w_floor_oh;
        end else begin
            w_state_n = (w_pending_n != '0) ? SERVE : IDLE;
        end
        w_req_n  = (w_state_n == DOOR) ? (4'b0001 << w_df_n) : w_pending_n;
        w_pcnt_n = 3'(w_pending_n[0]) + 3'(w_pending_n[1]) + 3'(w_pending_n[2]) + 3'(w_pending_n[3]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_btn_prev <= '0;
            r_pending  <= '0;
            r_df       <= '0;
            r_cnt      <= '0;
            r_req      <= '0;
            r_door     <= 1'b0;
            r_busy     <= 1'b0;
            r_pcnt     <= '0;
        end else begin
            r_state    <= w_state_n;
            r_btn_prev <= i_btn;
            r_pending  <= w_pending_n;
            r_df       <= w_df_n;
            r_cnt      <= w_cnt_n;
            r_req      <= w_req_n;
            r_door     <= (w_state_n == DOOR);
            r_busy     <= (w_pending_n != '0) || (w_state_n == DOOR);
            r_pcnt     <= w_pcnt_n;
        end
    end

    assign {o_rd, o_rc, o_rb, o_ra} = r_req;
    assign o_door_open   = r_door;
    assign o_busy        = r_busy;
    assign o_pending_cnt = r_pcnt;
endmodule

// File: tb/tb_elevator_call_panel.sv
// tb_elevator_call_panel: directed vectors for elevator_call_panel; expected
// values are {door_open, busy, pending_cnt[2:0], rd, rc, rb, ra}.
module tb_elevator_call_panel;
    logic       i_clk, i_rst_n;
    logic [3:0] i_btn;
    logic [1:0] i_floor;
    logic       o_ra, o_rb, o_rc, o_rd, o_door_open, o_busy;
    logic [2:0] o_pending_cnt;
    int         n_vec = 0;
    int         n_err = 0;

    elevator_call_panel #(.DWELL_CYCLES(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn), .i_floor(i_floor),
        .o_ra(o_ra), .o_rb(o_rb), .o_rc(o_rc), .o_rd(o_rd),
        .o_door_open(o_door_open), .o_busy(o_busy), .o_pending_cnt(o_pending_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {o_door_open, o_busy, o_pending_cnt, o_rd, o_rc, o_rb, o_ra};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with every button held, car at A.
        i_rst_n = 1'b1; i_btn = 4'b1111; i_floor = 2'd0;
        #1 i_rst_n = 1'b0;
        #1 chk("rst_async", 9'b0_0_000_0000);
        tick(); tick();
        chk("rst_held", 9'b0_0_000_0000);
        i_rst_n = 1'b1;
        tick(); chk("rel_door1", 9'b1_1_011_0001);
        tick(); chk("rel_door2", 9'b1_1_011_0001);
        tick(); chk("rel_door3", 9'b1_1_011_0001);
        tick(); chk("rel_door4", 9'b1_1_011_0001);
        tick(); chk("rel_exit",  9'b0_1_011_1110);
        // Single call to C.
        i_rst_n = 1'b0; i_btn = 4'b0000;
        #1 chk("rst2", 9'b0_0_000_0000);
        i_rst_n = 1'b1;
        tick(); chk("idle", 9'b0_0_000_0000);
        i_btn = 4'b0100;
        tick(); chk("c_press", 9'b0_1_001_0100);
        i_btn = 4'b0000;
        tick(); chk("c_pend", 9'b0_1_001_0100);
        i_floor = 2'd2;
        tick(); chk("c_door1", 9'b1_1_000_0100);
        tick(); chk("c_door2", 9'b1_1_000_0100);
        tick(); chk("c_door3", 9'b1_1_000_0100);
        tick(); chk("c_door4", 9'b1_1_000_0100);
        tick(); chk("c_idle",  9'b0_0_000_0000);
        // Multiple calls, B then D.
        i_floor = 2'd0; i_btn = 4'b1010;
        tick(); chk("bd_press", 9'b0_1_010_1010);
        i_btn = 4'b0000; i_floor = 2'd1;
        tick(); chk("b_door1", 9'b1_1_001_0010);
        tick(); chk("b_door2", 9'b1_1_001_0010);
        tick(); chk("b_door3", 9'b1_1_001_0010);
        tick(); chk("b_door4", 9'b1_1_001_0010);
        tick(); chk("b_exit",  9'b0_1_001_1000);
        // Arrival at D with a reopen press on the third dwell cycle.
        i_floor = 2'd3;
        tick(); chk("d_door1", 9'b1_1_000_1000);
        tick(); chk("d_door2", 9'b1_1_000_1000);
        tick(); chk("d_door3", 9'b1_1_000_1000);
        i_btn = 4'b1000;
        tick(); chk("d_reload", 9'b1_1_000_1000);
        i_btn = 4'b0000;
        tick(); chk("d_door5", 9'b1_1_000_1000);
        tick(); chk("d_door6", 9'b1_1_000_1000);
        tick(); chk("d_door7", 9'b1_1_000_1000);
        tick(); chk("d_exit",  9'b0_0_000_0000);
        // Held button counts once; arrival at an uncalled floor opens nothing.
        i_floor = 2'd0; i_btn = 4'b0010;
        tick(); chk("hold_first", 9'b0_1_001_0010);
        for (int k = 0; k < 9; k++) tick();
        chk("hold_last", 9'b0_1_001_0010);
        i_btn = 4'b0000; i_floor = 2'd3;
        tick(); chk("no_call_arrival", 9'b0_1_001_0010);
        tick(); chk("no_call_stay", 9'b0_1_001_0010);
        // Reset mid-dwell with A and C pending.
        i_rst_n = 1'b0;
        #1 i_rst_n = 1'b1;
        i_floor = 2'd3; i_btn = 4'b1101;
        tick(); chk("mid_door1", 9'b1_1_010_1000);
        i_btn = 4'b0000;
        tick(); chk("mid_door2", 9'b1_1_010_1000);
        #2 i_rst_n = 1'b0;
        #1 chk("mid_rst_async", 9'b0_0_000_0000);
        tick();
        i_rst_n = 1'b1;
        tick(); chk("mid_rst_idle", 9'b0_0_000_0000);
        tick(); chk("mid_rst_stay", 9'b0_0_000_0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
